uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 139 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte queue placed behind a UART receiver.
//
// Each rising edge of rx_done pushes d_in. The queue is first-word-fall-through:
// the head byte sits on rd_data whenever empty=0, and rd_en pops it. empty and full
// are derived only from the registered entry count, so neither has a combinational
// path from any input.
//
// Optional feature:
//   UART_RX_FIFO_OVF_EN - when defined, ovf is a sticky flag. It is set on the cycle
//   after a push is dropped because the queue is full, and it is cleared by ovf_clr.
//   If ovf_clr and a dropped push occur in the same cycle, the set wins. When the
//   macro is not defined, ovf is tied to 0 and ovf_clr is ignored.
//
// Ports:
//   clk      in   system clock; all state updates on its rising edge
//   rst_n    in   synchronous active-low reset
//   rx_done  in   receiver done level; one push per rising edge
//   d_in     in   received byte, valid while rx_done is high
//   rd_en    in   pop request; ignored while empty
//   rd_data  out  head-of-queue byte; don't-care while empty
//   empty    out  queue holds no entries
//   full     out  queue holds DEPTH entries
//   level    out  entry count, 0..DEPTH
//   ovf      out  sticky overflow flag (constant 0 unless the macro is defined)
//   ovf_clr  in   clears ovf
module uart_rx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_done,
    input  logic [DATA_W-1:0] d_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam logic [ADDR_W:0]   LevelFull = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LevelOne  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              rx_done_q;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic              drop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LevelFull);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        push  = rx_done & ~rx_done_q;
        pop   = rd_en & ~empty;
        // A pop in the same cycle frees the slot, so a push into a full queue is
        // still accepted then. The new byte lands at wr_ptr, which equals rd_ptr
        // when full, and the old head leaves in that same cycle.
        wr_en = push & (~full | pop);
        drop  = push & full & ~pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        if (wr_en && !pop) begin
            level_d = level_q + LevelOne;
        end else if (!wr_en && pop) begin
            level_d = level_q - LevelOne;
        end
    end

    // rx_done_q resets high so that an rx_done held high through reset release
    // does not count as a new frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rx_done_q <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rx_done_q <= rx_done;
        end
    end

    // Storage is not reset; a write in a reset cycle is suppressed.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_q[wr_ptr_q] <= d_in;
        end
    end

`ifdef UART_RX_FIFO_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_clr ^ drop;
    assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo. Every byte the stimulus expects to be accepted is
// appended to a scoreboard queue. A monitor process pops the expected head and
// compares it with rd_data whenever the consumer pops, that is, whenever
// rd_en=1 and empty=0.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_done;
    logic [7:0] d_in;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       ovf;
    logic       ovf_clr;

    int passed = 0;
    int total  = 0;
    logic [7:0] exp_q[$];

`ifdef UART_RX_FIFO_OVF_EN
    localparam int ExpOvf = 1;
`else
    localparam int ExpOvf = 0;
`endif

    uart_rx_fifo #(
        .DATA_W(8),
        .DEPTH (16),
        .ADDR_W(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_done(rx_done),
        .d_in   (d_in),
        .rd_en  (rd_en),
        .rd_data(rd_data),
        .empty  (empty),
        .full   (full),
        .level  (level),
        .ovf    (ovf),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: sample away from the rising edge, on the cycle in which a pop is accepted.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rd_en === 1'b1 && empty === 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL pop_unexpected: got %0h expected nothing queued", rd_data);
            end else begin
                check("pop_data", int'(rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accept);
        d_in    = b;
        rx_done = 1'b1;
        if (accept) exp_q.push_back(b);
        tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n   = 1'b0;
        rx_done = 1'b0;
        d_in    = '0;
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
        tick();
        tick();
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_level", int'(level), 0);
        check("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        tick();

        // Single byte; the data is visible one cycle after the push edge.
        d_in    = 8'hA5;
        rx_done = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        check("lat_empty", int'(empty), 0);
        check("lat_level", int'(level), 1);
        check("lat_data", int'(rd_data), 'hA5);
        rx_done = 1'b0;
        tick();
        pop_one();
        check("pop1_empty", int'(empty), 1);
        check("pop1_level", int'(level), 0);
        // A pop request while empty is ignored.
        pop_one();
        check("pop_empty_level", int'(level), 0);

        // A long rx_done level is still a single push.
        d_in    = 8'h3C;
        rx_done = 1'b1;
        exp_q.push_back(8'h3C);
        repeat (20) tick();
        check("long_level", int'(level), 1);
        rx_done = 1'b0;
        tick();
        push_byte(8'h3D, 1'b1);
        check("second_level", int'(level), 2);
        pop_one();
        pop_one();
        check("drain2_empty", int'(empty), 1);

        // Fill the queue, then check that a further push is dropped and sets ovf.
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
        check("fill_full", int'(full), 1);
        check("fill_level", int'(level), 16);
        check("fill_ovf", int'(ovf), 0);
        push_byte(8'hFF, 1'b0);
        check("drop_level", int'(level), 16);
        check("drop_ovf", int'(ovf), ExpOvf);
        for (int i = 0; i < 16; i++) pop_one();
        check("drain16_empty", int'(empty), 1);
        check("ovf_sticky", int'(ovf), ExpOvf);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", int'(ovf), 0);

        // Full queue: ovf_clr in the same cycle as a dropped push (the set wins).
        for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i), 1'b1);
        d_in    = 8'hEE;
        rx_done = 1'b1;
        ovf_clr = 1'b1;
        tick();
        rx_done = 1'b0;
        ovf_clr = 1'b0;
        tick();
        check("ovf_set_wins", int'(ovf), ExpOvf);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr2", int'(ovf), 0);

        // Full queue with a push and a pop in the same cycle: both are accepted.
        d_in    = 8'h77;
        rx_done = 1'b1;
        rd_en   = 1'b1;
        exp_q.push_back(8'h77);
        tick();
        rx_done = 1'b0;
        rd_en   = 1'b0;
        check("fullpp_level", int'(level), 16);
        check("fullpp_full", int'(full), 1);
        check("fullpp_ovf", int'(ovf), 0);
        tick();
        for (int i = 0; i < 16; i++) pop_one();
        check("drain77_empty", int'(empty), 1);

        // Empty queue with a push and a pop in the same cycle: only the push takes effect.
        d_in    = 8'h11;
        rx_done = 1'b1;
        rd_en   = 1'b1;
        exp_q.push_back(8'h11);
        tick();
        rx_done = 1'b0;
        rd_en   = 1'b0;
        check("emptypp_level", int'(level), 1);
        check("emptypp_data", int'(rd_data), 'h11);
        tick();
        for (int i = 0; i < 40; i++) begin
            d_in    = 8'(8'h40 + i);
            rx_done = 1'b1;
            rd_en   = 1'b1;
            exp_q.push_back(d_in);
            tick();
            rx_done = 1'b0;
            rd_en   = 1'b0;
            check("wrap_level", int'(level), 1);
            tick();
        end
        pop_one();
        check("wrap_empty", int'(empty), 1);

        // rx_done held high across reset release does not push.
        rst_n   = 1'b0;
        rx_done = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("rstrel_empty", int'(empty), 1);
        check("rstrel_level", int'(level), 0);
        rx_done = 1'b0;
        tick();
        push_byte(8'h5A, 1'b1);
        check("after_rel_level", int'(level), 1);
        push_byte(8'h5B, 1'b1);
        push_byte(8'h5C, 1'b1);
        check("three_level", int'(level), 3);
        // Reset in the middle of operation discards everything queued.
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        check("midrst_empty", int'(empty), 1);
        check("midrst_level", int'(level), 0);
        check("midrst_full", int'(full), 0);
        tick();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
